// File: rtl/selftrigger_event_framer.sv
`timescale 1ns/1ps
// Per-channel event framer: keeps a pretrigger ring of filtered samples and
// streams one header + PRE/POST sample record per accepted trigger.
module selftrigger_event_framer #(
    parameter int PRE  = 64,
    parameter int POST = 448,
    parameter int AW   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trigger,
    input  logic [15:0] din,
    input  logic [15:0] baseline,
    input  logic [63:0] timestamp,
    input  logic [7:0]  ch_id,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        busy,
    output logic [15:0] dropped_count
);

    localparam int DEPTH = 1 << AW;
    localparam int FW    = $clog2(PRE + 1);

    localparam logic [AW-1:0] PRE_A    = AW'(PRE);
    localparam logic [AW-1:0] LAST_IDX = AW'(PRE + POST - 1);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [FW-1:0] PRE_F    = FW'(PRE);
    localparam logic [FW-1:0] ONE_F    = FW'(1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   ring_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [2:0]    hdr_idx_q, hdr_idx_d;
    logic [63:0]   ts_l_q, ts_l_d;
    logic [15:0]   bl_l_q, bl_l_d;
    logic [7:0]    ch_l_q, ch_l_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;

    logic        accept;
    logic        load;
    logic        rd_load;
    logic [15:0] hdr_word;

    assign m_tdata       = tdata_q;
    assign m_tvalid      = tvalid_q;
    assign m_tlast       = tlast_q;
    assign m_tuser       = tuser_q;
    assign busy          = (state_q != IDLE);
    assign dropped_count = drop_q;

    always_ff @(posedge clk) begin
        ring_q[wr_ptr_q] <= din;
    end

    always_comb begin
        hdr_word = {8'hA5, ch_l_q};
        unique case (hdr_idx_q)
            3'd1:    hdr_word = ts_l_q[63:48];
            3'd2:    hdr_word = ts_l_q[47:32];
            3'd3:    hdr_word = ts_l_q[31:16];
            3'd4:    hdr_word = ts_l_q[15:0];
            3'd5:    hdr_word = bl_l_q;
            default: hdr_word = {8'hA5, ch_l_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q + ONE_A;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        hdr_idx_d = hdr_idx_q;
        ts_l_d    = ts_l_q;
        bl_l_d    = bl_l_q;
        ch_l_d    = ch_l_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        rd_load   = 1'b0;

        if (fill_q != PRE_F) begin
            fill_d = fill_q + ONE_F;
        end

        accept = trigger && enable && (state_q == IDLE) && (fill_q == PRE_F);
        if (trigger && !accept && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        // output register takes a new word when empty or being consumed
        load = !tvalid_q || m_tready;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = HDR;
                    ts_l_d    = timestamp;
                    bl_l_d    = baseline;
                    ch_l_d    = ch_id;
                    rd_ptr_d  = wr_ptr_q - PRE_A;
                    hdr_idx_d = 3'd1;
                    ovf_d     = 1'b0;
                    tdata_d   = {8'hA5, ch_id};
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    tuser_d   = 1'b0;
                end
            end
            HDR: begin
                if (load) begin
                    if (ovf_q) begin
                        tdata_d = 16'h0000;
                        tlast_d = 1'b1;
                        tuser_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        tdata_d   = hdr_word;
                        hdr_idx_d = hdr_idx_q + 3'd1;
                        if (hdr_idx_q == 3'd5) begin
                            state_d = DATA;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            DATA: begin
                if (load) begin
                    if (ovf_q) begin
                        tdata_d = 16'h0000;
                        tlast_d = 1'b1;
                        tuser_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        rd_load  = 1'b1;
                        tdata_d  = ring_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + ONE_A;
                        cnt_d    = cnt_q + ONE_A;
                        if (cnt_q == LAST_IDX) begin
                            tlast_d = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (load) begin
                    tdata_d  = 16'h0000;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tuser_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // this write fills the ring with unread samples: oldest is lost
        if (((state_q == HDR) || (state_q == DATA)) && !ovf_q && !rd_load
            && ((wr_ptr_q + ONE_A) == rd_ptr_q)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            hdr_idx_q <= '0;
            ts_l_q    <= '0;
            bl_l_q    <= '0;
            ch_l_q    <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            hdr_idx_q <= hdr_idx_d;
            ts_l_q    <= ts_l_d;
            bl_l_q    <= bl_l_d;
            ch_l_q    <= ch_l_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
        end
    end

endmodule

// File: tb/tb_selftrigger_event_framer.sv
`timescale 1ns/1ps
// Directed bench for selftrigger_event_framer (PRE=4, POST=8).
// A deep-ring twin instance serves the random-backpressure frame.
module tb_selftrigger_event_framer;

    localparam int PRE  = 4;
    localparam int POST = 8;
    localparam int NW   = 6 + PRE + POST;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        user;
    } word_t;

    typedef struct {
        logic [7:0]  ch;
        logic [63:0] ts;
        logic [15:0] bl;
    } cfg_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        trigger;
    logic [15:0] din;
    logic [15:0] baseline;
    logic [63:0] timestamp;
    logic [7:0]  ch_id;
    logic        m_tready;

    logic [15:0] n_tdata, w_tdata;
    logic        n_tvalid, w_tvalid;
    logic        n_tlast, w_tlast;
    logic        n_tuser, w_tuser;
    logic        n_busy, w_busy;
    logic [15:0] n_drop, w_drop;

    int cyc = 0;
    bit use_w;
    logic [15:0] md;
    logic        mv, ml, mu;

    int    n_chk;
    int    n_fail;
    word_t cap[$];
    word_t exp_w[NW];
    cfg_t  cfg[4];
    int    last_seen;
    int    first_cyc;
    int    last_cyc;
    int    trig_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign din = cyc[15:0];
    assign md  = use_w ? w_tdata  : n_tdata;
    assign mv  = use_w ? w_tvalid : n_tvalid;
    assign ml  = use_w ? w_tlast  : n_tlast;
    assign mu  = use_w ? w_tuser  : n_tuser;

    selftrigger_event_framer #(.PRE(PRE), .POST(POST), .AW(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .din(din), .baseline(baseline), .timestamp(timestamp),
        .ch_id(ch_id), .m_tdata(n_tdata), .m_tvalid(n_tvalid),
        .m_tready(m_tready), .m_tlast(n_tlast), .m_tuser(n_tuser),
        .busy(n_busy), .dropped_count(n_drop)
    );

    selftrigger_event_framer #(.PRE(PRE), .POST(POST), .AW(7)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .din(din), .baseline(baseline), .timestamp(timestamp),
        .ch_id(ch_id), .m_tdata(w_tdata), .m_tvalid(w_tvalid),
        .m_tready(m_tready), .m_tlast(w_tlast), .m_tuser(w_tuser),
        .busy(w_busy), .dropped_count(w_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        enable   = 1'b1;
        trigger  = 1'b0;
        m_tready = 1'b1;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic build_exp(input int c, input int td);
        exp_w[0] = '{{8'hA5, cfg[c].ch}, 1'b0, 1'b0};
        exp_w[1] = '{cfg[c].ts[63:48], 1'b0, 1'b0};
        exp_w[2] = '{cfg[c].ts[47:32], 1'b0, 1'b0};
        exp_w[3] = '{cfg[c].ts[31:16], 1'b0, 1'b0};
        exp_w[4] = '{cfg[c].ts[15:0], 1'b0, 1'b0};
        exp_w[5] = '{cfg[c].bl, 1'b0, 1'b0};
        for (int k = 0; k < PRE + POST; k++) begin
            exp_w[6 + k] = '{16'(td - PRE + k), (k == PRE + POST - 1), 1'b0};
        end
    endtask

    task automatic fire(input int c);
        ch_id     = cfg[c].ch;
        timestamp = cfg[c].ts;
        baseline  = cfg[c].bl;
        trig_cyc  = cyc;
        build_exp(c, cyc);
        cap.delete();
        last_seen = 0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic wait_last(input int budget, input bit rnd);
        int i = 0;
        while (last_seen == 0 && i < budget) begin
            if (rnd) m_tready = 1'($urandom_range(0, 1));
            step();
            i++;
        end
        chk("frame_end", 64'(last_seen), 64'd1);
    endtask

    task automatic check_frame(input string nm);
        chk($sformatf("%s_len", nm), 64'(cap.size()), 64'(NW));
        for (int i = 0; i < NW; i++) begin
            if (i < cap.size()) begin
                chk($sformatf("%s_w%0d_data", nm, i), 64'(cap[i].data),
                    64'(exp_w[i].data));
                chk($sformatf("%s_w%0d_last_user", nm, i),
                    64'({cap[i].last, cap[i].user}),
                    64'({exp_w[i].last, exp_w[i].user}));
            end
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        use_w     = 1'b0;
        last_seen = 0;
        first_cyc = 0;
        last_cyc  = 0;
        trig_cyc  = 0;
        reset     = 1'b0;
        enable    = 1'b1;
        trigger   = 1'b0;
        m_tready  = 1'b1;
        baseline  = '0;
        timestamp = '0;
        ch_id     = '0;
        cfg[0] = '{8'h07, 64'h0123_4567_89AB_CDEF, 16'hFF80};
        cfg[1] = '{8'h2C, 64'hDEAD_BEEF_0000_1111, 16'h0042};
        cfg[2] = '{8'h91, 64'h8000_0000_0000_0001, 16'h7FFF};
        cfg[3] = '{8'hFE, 64'h0000_1234_5678_9ABC, 16'h1357};

        fork
            begin : monitor
                logic        prev_stall;
                logic [15:0] pd;
                logic        pl, pu;
                prev_stall = 1'b0;
                pd = '0;
                pl = 1'b0;
                pu = 1'b0;
                forever begin
                    @(negedge clk);
                    if (reset && prev_stall) begin
                        n_chk++;
                        if (!(mv && md == pd && ml == pl && mu == pu)) begin
                            n_fail++;
                            $display("FAIL stall_hold: got v%0b %h l%0b u%0b expected v1 %h l%0b u%0b",
                                     mv, md, ml, mu, pd, pl, pu);
                        end
                    end
                    if (reset && mv && m_tready) begin
                        cap.push_back('{md, ml, mu});
                        if (cap.size() == 1) first_cyc = cyc;
                        if (ml) begin
                            last_seen = 1;
                            last_cyc  = cyc;
                        end
                    end
                    prev_stall = reset && mv && !m_tready;
                    pd = md;
                    pl = ml;
                    pu = mu;
                end
            end
        join_none

        step();
        step();
        step();
        chk("rst_valid", 64'(n_tvalid), 64'd0);
        chk("rst_busy", 64'(n_busy), 64'd0);
        chk("rst_drop", 64'(n_drop), 64'd0);
        chk("rst_data", 64'(n_tdata), 64'd0);
        chk("rst_last_user", 64'({n_tlast, n_tuser}), 64'd0);
        reset = 1'b1;

        // basic frame, trigger on din=20
        while (cyc < 20) step();
        fire(0);
        wait_last(60, 1'b0);
        check_frame("s1");
        chk("s1_first_cyc", 64'(first_cyc), 64'(trig_cyc + 1));
        chk("s1_last_cyc", 64'(last_cyc), 64'(trig_cyc + 6 + PRE + POST));
        chk("s1_busy_after", 64'(n_busy), 64'd0);
        chk("s1_drop", 64'(n_drop), 64'd0);

        // trigger before the ring holds PRE samples
        do_reset();
        step();
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("s2_drop", 64'(n_drop), 64'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (n_tvalid) seen = 1'b1;
                step();
            end
            chk("s2_no_valid", 64'(seen), 64'd0);
        end

        // enable=0 trigger and trigger during DATA
        do_reset();
        repeat (6) step();
        enable  = 1'b0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        enable  = 1'b1;
        chk("s3_drop_en", 64'(n_drop), 64'd1);
        chk("s3_idle", 64'(n_tvalid), 64'd0);
        fire(1);
        repeat (10) step();
        chk("s3_busy", 64'(n_busy), 64'd1);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        wait_last(60, 1'b0);
        check_frame("s3");
        repeat (10) step();
        chk("s3_single", 64'(cap.size()), 64'(NW));
        chk("s3_valid_off", 64'(n_tvalid), 64'd0);
        chk("s3_drop", 64'(n_drop), 64'd2);

        // random backpressure on the deep-ring instance
        use_w = 1'b1;
        do_reset();
        repeat (6) step();
        fire(2);
        wait_last(400, 1'b1);
        m_tready = 1'b1;
        check_frame("s4");
        chk("s4_drop", 64'(w_drop), 64'd0);
        use_w = 1'b0;

        // stall from H5 until the ring overflows
        do_reset();
        repeat (6) step();
        fire(3);
        repeat (5) step();
        m_tready = 1'b0;
        chk("s5_h5", 64'(n_tdata), 64'(cfg[3].bl));
        repeat (20) step();
        chk("s5_stall_busy", 64'(n_busy), 64'd1);
        chk("s5_stall_valid", 64'(n_tvalid), 64'd1);
        m_tready = 1'b1;
        wait_last(40, 1'b0);
        chk("s5_len", 64'(cap.size()), 64'd7);
        if (cap.size() == 7) begin
            chk("s5_h5_cap", 64'(cap[5].data), 64'(cfg[3].bl));
            chk("s5_trunc_data", 64'(cap[6].data), 64'd0);
            chk("s5_trunc_last_user", 64'({cap[6].last, cap[6].user}), 64'd3);
        end
        chk("s5_busy_fall", 64'(n_busy), 64'd0);
        fire(0);
        wait_last(60, 1'b0);
        check_frame("s5b");

        // reset in the middle of DATA
        do_reset();
        repeat (6) step();
        enable  = 1'b0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        enable  = 1'b1;
        chk("s6_pre_drop", 64'(n_drop), 64'd1);
        fire(1);
        repeat (10) step();
        chk("s6_mid_valid", 64'(n_tvalid), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("s6_valid", 64'(n_tvalid), 64'd0);
        chk("s6_busy", 64'(n_busy), 64'd0);
        chk("s6_drop", 64'(n_drop), 64'd0);
        chk("s6_no_last", 64'(last_seen), 64'd0);
        repeat (6) step();
        fire(2);
        wait_last(60, 1'b0);
        check_frame("s6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
